// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state type and sign helpers for the
// floating-point arithmetic blocks.
package fp_pkg;

    localparam int XLEN      = 32;
    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;
    localparam int BIAS      = 127;
    localparam int DIV_ITERS = 26;

    localparam logic [XLEN-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [XLEN-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORMALIZE,
        ROUND,
        DONE
    } state_t;

    function automatic logic [XLEN-1:0] signed_inf(input logic s);
        return POS_INF | {s, {(XLEN-1){1'b0}}};
    endfunction

    function automatic logic [XLEN-1:0] signed_zero(input logic s);
        return {s, {(XLEN-1){1'b0}}};
    endfunction

endpackage

// File: rtl/float_division_if.sv
// Request/response bundle of the iterative divider: the requester drives
// start/A/B, the divider returns busy/done/result and exception flags.
interface float_division_if #(
    parameter int XLEN = fp_pkg::XLEN
);
    logic            start;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_by_zero;
    logic            overflow;
    logic            underflow;

    modport master (
        output start, A, B,
        input  busy, done, result, div_by_zero, overflow, underflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, result, div_by_zero, overflow, underflow
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational operand classifier; subnormals (exp = 0) report as zero since
// the arithmetic blocks flush them.
module fp_classify
    import fp_pkg::*;
(
    input  logic [EXP_BITS-1:0]  exp,
    input  logic [MANT_BITS-1:0] frac,
    output logic                 is_zero,
    output logic                 is_inf,
    output logic                 is_nan,
    output logic                 is_normal
);

    always_comb begin
        is_zero   = (exp == '0);
        is_inf    = (exp == '1) && (frac == '0);
        is_nan    = (exp == '1) && (frac != '0);
        is_normal = (exp != '0) && (exp != '1);
    end

endmodule

// File: rtl/float_division.sv
// Single-precision divider: restoring mantissa division, one quotient bit per
// cycle, round-to-nearest-even, flush-to-zero; fixed 29-cycle latency.
module float_division
    import fp_pkg::*;
#(
    parameter int XLEN = fp_pkg::XLEN
) (
    input logic             clk,
    input logic             rst,
    float_division_if.slave bus
);

    localparam int MW = MANT_BITS + 1;
    localparam int QW = DIV_ITERS;
    localparam int RW = MW + 1;
    localparam logic [4:0]        LAST_ITER = 5'(DIV_ITERS - 1);
    localparam logic signed [9:0] BIAS_S    = 10'(BIAS);
    localparam logic signed [9:0] EXP_MAX   = 10'((1 << EXP_BITS) - 1);

    state_t     state_q, state_d;
    logic [4:0] iter_q;
    logic       accept;
    logic       busy_c, done_c;

    logic [XLEN-1:0] a_p0, b_p0;
    logic a_zero, a_inf, a_nan, a_norm;
    logic b_zero, b_inf, b_nan, b_norm;

    logic                  sign_u, spec_u, dbz_u;
    logic signed [9:0]     exp_u;
    logic [XLEN-1:0]       spec_res_u;

    logic                  sign_p1, spec_p1, spec_dbz_p1;
    logic [XLEN-1:0]       spec_res_p1;
    logic signed [9:0]     exp_p1;
    logic [RW-1:0]         rem_p1;
    logic [MW-1:0]         div_p1;
    logic [QW-1:0]         quo_p1;

    logic                  take;
    logic [RW-1:0]         diff, rem_sel;

    logic [QW-1:0]         mant_p2;
    logic signed [9:0]     exp_p2;
    logic                  sticky_p2;

    logic [MW:0]           rnd;
    logic signed [9:0]     exp_r;
    logic [MANT_BITS-1:0]  frac_r;
    logic [XLEN+1:0]       pack_r;

    logic [XLEN-1:0]       result_q;
    logic                  dbz_q, ovf_q, unf_q;

    // m holds 24 significand bits, then guard, then round; a carry-out lands in bit MW.
    function automatic logic [MW:0] round_rne(input logic [QW-1:0] m, input logic sticky);
        logic up;
        up = m[1] & (m[0] | sticky | m[2]);
        return {1'b0, m[QW-1:2]} + {{MW{1'b0}}, up};
    endfunction

    // Returns {overflow, underflow, word}.
    function automatic logic [XLEN+1:0] saturate(input logic s, input logic signed [9:0] e,
                                                 input logic [MANT_BITS-1:0] f);
        if (e >= EXP_MAX) begin
            return {2'b10, signed_inf(s)};
        end else if (e <= 10'sd0) begin
            return {2'b01, signed_zero(s)};
        end else begin
            return {2'b00, s, e[EXP_BITS-1:0], f};
        end
    endfunction

    assign accept = (state_q == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.start) state_d = UNPACK;
            UNPACK:    state_d = DIVIDE;
            DIVIDE:    if (iter_q == LAST_ITER) state_d = NORMALIZE;
            NORMALIZE: state_d = ROUND;
            ROUND:     state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q == UNPACK) || (state_q == DIVIDE) ||
                 (state_q == NORMALIZE) || (state_q == ROUND);
        done_c = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
        end else if (state_q == DIVIDE) begin
            iter_q <= iter_q + 5'd1;
        end else begin
            iter_q <= '0;
        end
    end

    fp_classify u_cls_a (
        .exp      (a_p0[MANT_BITS +: EXP_BITS]),
        .frac     (a_p0[MANT_BITS-1:0]),
        .is_zero  (a_zero),
        .is_inf   (a_inf),
        .is_nan   (a_nan),
        .is_normal(a_norm)
    );

    fp_classify u_cls_b (
        .exp      (b_p0[MANT_BITS +: EXP_BITS]),
        .frac     (b_p0[MANT_BITS-1:0]),
        .is_zero  (b_zero),
        .is_inf   (b_inf),
        .is_nan   (b_nan),
        .is_normal(b_norm)
    );

    // Stage p0 -> p1: sign, biased exponent and special-case outcome.
    always_comb begin
        sign_u     = a_p0[XLEN-1] ^ b_p0[XLEN-1];
        exp_u      = $signed({2'b00, a_p0[MANT_BITS +: EXP_BITS]})
                   - $signed({2'b00, b_p0[MANT_BITS +: EXP_BITS]}) + BIAS_S;
        spec_u     = !(a_norm && b_norm);
        dbz_u      = 1'b0;
        spec_res_u = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res_u = QNAN;
        end else if (a_inf) begin
            spec_res_u = signed_inf(sign_u);
        end else if (b_inf || a_zero) begin
            spec_res_u = signed_zero(sign_u);
        end else if (b_zero) begin
            spec_res_u = signed_inf(sign_u);
            dbz_u      = 1'b1;
        end
    end

    // Stage p1 iteration: trial subtraction of the divisor from the partial remainder.
    always_comb begin
        take    = (rem_p1 >= {1'b0, div_p1});
        diff    = rem_p1 - {1'b0, div_p1};
        rem_sel = take ? diff : rem_p1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0 <= bus.A;
            b_p0 <= bus.B;
        end
        case (state_q)
            UNPACK: begin
                sign_p1     <= sign_u;
                exp_p1      <= exp_u;
                rem_p1      <= {1'b0, 1'b1, a_p0[MANT_BITS-1:0]};
                div_p1      <= {1'b1, b_p0[MANT_BITS-1:0]};
                quo_p1      <= '0;
                spec_p1     <= spec_u;
                spec_res_p1 <= spec_res_u;
                spec_dbz_p1 <= dbz_u;
            end
            DIVIDE: begin
                rem_p1 <= rem_sel << 1;
                quo_p1 <= {quo_p1[QW-2:0], take};
            end
            NORMALIZE: begin
                mant_p2   <= quo_p1[QW-1] ? quo_p1 : {quo_p1[QW-2:0], 1'b0};
                exp_p2    <= quo_p1[QW-1] ? exp_p1 : exp_p1 - 10'sd1;
                sticky_p2 <= |rem_p1;
            end
            default: ;
        endcase
    end

    // Stage p2 -> output: round, fold carry into the exponent, saturate.
    always_comb begin
        rnd    = round_rne(mant_p2, sticky_p2);
        exp_r  = rnd[MW] ? exp_p2 + 10'sd1 : exp_p2;
        frac_r = rnd[MW] ? rnd[MW-1:1] : rnd[MANT_BITS-1:0];
        pack_r = saturate(sign_p1, exp_r, frac_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (state_q == ROUND) begin
            if (spec_p1) begin
                result_q <= spec_res_p1;
                dbz_q    <= spec_dbz_p1;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
            end else begin
                {ovf_q, unf_q, result_q} <= pack_r;
                dbz_q                    <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_float_division.sv
// Directed and randomized bench for float_division against an exact-integer
// reference model of IEEE single-precision division with flush-to-zero.
module tb_float_division;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    float_division_if #(.XLEN(32)) bus ();

    float_division #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {29'd0, bus.div_by_zero, bus.overflow, bus.underflow};
    endfunction

    // Reference: {div_by_zero, overflow, underflow, result}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s, az, ai, an, bz, bi, bn;
        int ea, eb, e, sh;
        longint unsigned ma, mb, n, r, rb, half, sig;
        s  = a[31] ^ b[31];
        az = (a[30:23] == 8'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bz = (b[30:23] == 8'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (an || bn || (az && bz) || (ai && bi)) return {3'b000, 32'h7FC00000};
        if (ai) return {3'b000, s, 8'hFF, 23'd0};
        if (bi || az) return {3'b000, s, 31'd0};
        if (bz) return {3'b100, s, 8'hFF, 23'd0};
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        n  = (ma << 40) / mb;
        r  = (ma << 40) % mb;
        if (n >= (64'd1 << 40)) begin
            sh = 17;
            e  = ea - eb + 127;
        end else begin
            sh = 16;
            e  = ea - eb + 126;
        end
        sig  = n >> sh;
        rb   = n & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rb > half || (rb == half && (r != 64'd0 || sig[0]))) sig++;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e++;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, s, 31'd0};
        return {3'b000, s, e[7:0], sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'd0;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'($urandom_range(1, 4));
            4: v[30:23] = 8'($urandom_range(250, 254));
            5: v[22:0] = 23'd0;
            6: v[30:23] = 8'($urandom_range(110, 144));
            default: ;
        endcase
        return v;
    endfunction

    // Caller is #1 after a rising edge; start is sampled on the next edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit glitch,
                          input logic [34:0] exp_v);
        logic busy_ok;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            if (glitch && k == 5) begin
                bus.start = 1'b1;
                bus.A = $urandom;
                bus.B = $urandom;
            end
            if (glitch && k == 6) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 1'b0;
        end
        check("busy_window", 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        check("done_at_29", 32'(bus.done), 32'd1);
        check("result", bus.result, exp_v[31:0]);
        check("flags", flags_now(), {29'd0, exp_v[34:32]});
        if (glitch) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_single", 32'(bus.done), 32'd0);
        check("result_hold", bus.result, exp_v[31:0]);
        if (glitch) begin
            @(posedge clk); #1;
            check("start_in_done", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int done_cnt;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_flags", flags_now(), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'h40C00000, 32'h3FC00000, 1'b0, {3'b000, 32'h40800000});
        run_op(32'h3F800000, 32'h40400000, 1'b0, {3'b000, 32'h3EAAAAAB});
        run_op(32'hC04CCCCD, 32'hBF000000, 1'b0, {3'b000, 32'h40CCCCCD});
        run_op(32'h3F800000, 32'h00000000, 1'b0, {3'b100, 32'h7F800000});
        run_op(32'h00000000, 32'h00000000, 1'b0, {3'b000, 32'h7FC00000});
        run_op(32'h7F7FFFFF, 32'h3F000000, 1'b0, {3'b010, 32'h7F800000});
        run_op(32'h00800000, 32'h40000000, 1'b0, {3'b001, 32'h00000000});
        run_op(32'hFF800000, 32'h40000000, 1'b0, {3'b000, 32'hFF800000});
        run_op(32'h40000000, 32'hFF800000, 1'b0, {3'b000, 32'h80000000});
        run_op(32'h40C00000, 32'h3FC00000, 1'b1, {3'b000, 32'h40800000});

        // Abort in the middle of the divide iterations.
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_flags", flags_now(), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(32'h3F800000, 32'h40400000, 1'b0, {3'b000, 32'h3EAAAAAB});

        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            run_op(ra, rb, 1'b0, model(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
